// File: rtl/cajero_parametrizado_pkg.sv
// Shared definitions for the parametrised ATM controller.
// Holds the controller state encoding and the transaction-type codes
// sampled on TIPO_TRANS together with MONTO_STB.
package cajero_parametrizado_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        RECIBE_PIN,
        VERIFICA_PIN,
        ESPERA_MONTO,
        PROCESA,
        BLOQUEADO
    } estado_t;

    localparam logic TRANS_DEPOSITO = 1'b0;
    localparam logic TRANS_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_parametrizado_captura_pin.sv
// PIN capture: shift register plus digit counter.
// Ports:
//   clk, reset     clock and synchronous active-low reset
//   borrar         hold the digit counter at zero (controller not collecting digits)
//   stb, digito    keypad strobe and BCD digit; digit shifts into the LS nibble
//   pin_ingresado  digits collected so far, first digit ends up in the top nibble
//   pin_listo      combinational: the current strobe completes the N-digit PIN
module captura_pin #(
    parameter int unsigned N_DIGITOS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     borrar,
    input  logic                     stb,
    input  logic [3:0]               digito,
    output logic [4*N_DIGITOS-1:0]   pin_ingresado,
    output logic                     pin_listo
);

    localparam int unsigned CW = $clog2(N_DIGITOS + 1);

    logic [CW-1:0]            cuenta;
    logic [4*N_DIGITOS+3:0]   desplazado;

    always_comb begin
        desplazado = {pin_ingresado, digito};
        pin_listo  = stb && !borrar && (cuenta == CW'(N_DIGITOS - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cuenta        <= '0;
            pin_ingresado <= '0;
        end else if (borrar) begin
            cuenta <= '0;
        end else if (stb) begin
            pin_ingresado <= desplazado[4*N_DIGITOS-1:0];
            // Wrap to zero on the last digit so a retry starts clean.
            cuenta        <= pin_listo ? '0 : cuenta + CW'(1);
        end
    end

endmodule

// File: rtl/cajero_parametrizado.sv
// Parametrised ATM transaction controller.
// Captures an N-digit PIN, tracks failed attempts with warning and lockout,
// then executes one deposit or withdrawal against an internal balance.
// Ports:
//   CLK, RESET             clock, synchronous active-low reset
//   TARJETA_RECIBIDA       card present (level)
//   PIN                    correct PIN for the card, MS digit in top nibble
//   DIGITO, DIGITO_STB     keypad digit and its one-cycle strobe
//   TIPO_TRANS, MONTO,     transaction type (0 deposit, 1 withdrawal), amount,
//   MONTO_STB              and their one-cycle strobe
//   BALANCE                registered current balance
//   BALANCE_ACTUALIZADO,   one-cycle result pulses
//   ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO
//   ADVERTENCIA, BLOQUEO   registered status levels
module cajero_parametrizado
    import cajero_parametrizado_pkg::*;
#(
    parameter int unsigned          N_DIGITOS     = 4,
    parameter int unsigned          MONTO_W       = 32,
    parameter int unsigned          BAL_W         = 64,
    parameter int unsigned          MAX_INTENTOS  = 3,
    parameter logic [MONTO_W-1:0]   LIMITE_RETIRO = MONTO_W'(50000),
    parameter logic [BAL_W-1:0]     BALANCE_INI   = BAL_W'(1000)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     TARJETA_RECIBIDA,
    input  logic [4*N_DIGITOS-1:0]   PIN,
    input  logic [3:0]               DIGITO,
    input  logic                     DIGITO_STB,
    input  logic                     TIPO_TRANS,
    input  logic [MONTO_W-1:0]       MONTO,
    input  logic                     MONTO_STB,
    output logic [BAL_W-1:0]         BALANCE,
    output logic                     BALANCE_ACTUALIZADO,
    output logic                     ENTREGAR_DINERO,
    output logic                     PIN_INCORRECTO,
    output logic                     ADVERTENCIA,
    output logic                     BLOQUEO,
    output logic                     FONDOS_INSUFICIENTES,
    output logic                     LIMITE_EXCEDIDO
);

    localparam int unsigned FW = $clog2(MAX_INTENTOS + 1);
    localparam logic [FW-1:0] FALLOS_MAX  = FW'(MAX_INTENTOS);
    localparam logic [FW-1:0] FALLOS_AVISO = FW'(MAX_INTENTOS - 1);

    estado_t                  estado, estado_sig;
    logic [FW-1:0]            fallos, fallos_sig, fallos_mas;
    logic [BAL_W-1:0]         balance_sig;
    logic [MONTO_W-1:0]       monto_reg;
    logic                     tipo_reg;
    logic [BAL_W-1:0]         monto_ext;
    logic [BAL_W:0]           suma;

    logic                     act_sig, entregar_sig, pin_inc_sig;
    logic                     adv_sig, bloq_sig, fondos_sig, limite_sig;

    logic [4*N_DIGITOS-1:0]   pin_ingresado;
    logic                     pin_listo;
    logic                     borrar;

    // Counter is held at zero whenever digits are not being collected,
    // which also clears it on every entry to RECIBE_PIN.
    assign borrar = (estado != RECIBE_PIN);

    captura_pin #(
        .N_DIGITOS (N_DIGITOS)
    ) u_captura (
        .clk           (CLK),
        .reset         (RESET),
        .borrar        (borrar),
        .stb           (DIGITO_STB),
        .digito        (DIGITO),
        .pin_ingresado (pin_ingresado),
        .pin_listo     (pin_listo)
    );

    always_comb begin
        fallos_mas = fallos + FW'(1);
        monto_ext  = BAL_W'(monto_reg);
        suma       = {1'b0, BALANCE} + {1'b0, monto_ext};
    end

    always_comb begin
        estado_sig   = estado;
        fallos_sig   = fallos;
        balance_sig  = BALANCE;
        adv_sig      = ADVERTENCIA;
        bloq_sig     = BLOQUEO;
        act_sig      = 1'b0;
        entregar_sig = 1'b0;
        pin_inc_sig  = 1'b0;
        fondos_sig   = 1'b0;
        limite_sig   = 1'b0;

        case (estado)
            ESPERA_TARJETA: begin
                if (TARJETA_RECIBIDA) estado_sig = RECIBE_PIN;
            end
            RECIBE_PIN: begin
                if (pin_listo) estado_sig = VERIFICA_PIN;
            end
            VERIFICA_PIN: begin
                if (pin_ingresado == PIN) begin
                    estado_sig = ESPERA_MONTO;
                    fallos_sig = '0;
                    adv_sig    = 1'b0;
                end else begin
                    pin_inc_sig = 1'b1;
                    fallos_sig  = fallos_mas;
                    if (fallos_mas == FALLOS_MAX) begin
                        estado_sig = BLOQUEADO;
                        bloq_sig   = 1'b1;
                        adv_sig    = 1'b0;
                    end else begin
                        estado_sig = RECIBE_PIN;
                        if (fallos_mas == FALLOS_AVISO) adv_sig = 1'b1;
                    end
                end
            end
            ESPERA_MONTO: begin
                if (MONTO_STB) estado_sig = PROCESA;
            end
            PROCESA: begin
                estado_sig = ESPERA_TARJETA;
                if (tipo_reg == TRANS_RETIRO) begin
                    if (monto_reg > LIMITE_RETIRO) begin
                        limite_sig = 1'b1;
                    end else if (monto_ext > BALANCE) begin
                        fondos_sig = 1'b1;
                    end else begin
                        balance_sig  = BALANCE - monto_ext;
                        act_sig      = 1'b1;
                        entregar_sig = 1'b1;
                    end
                end else begin
                    balance_sig = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
                    act_sig     = 1'b1;
                end
            end
            BLOQUEADO: begin
                estado_sig = BLOQUEADO;
            end
            default: begin
                estado_sig = ESPERA_TARJETA;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            estado               <= ESPERA_TARJETA;
            fallos               <= '0;
            BALANCE              <= BALANCE_INI;
            monto_reg            <= '0;
            tipo_reg             <= TRANS_DEPOSITO;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            LIMITE_EXCEDIDO      <= 1'b0;
        end else begin
            estado               <= estado_sig;
            fallos               <= fallos_sig;
            BALANCE              <= balance_sig;
            BALANCE_ACTUALIZADO  <= act_sig;
            ENTREGAR_DINERO      <= entregar_sig;
            PIN_INCORRECTO       <= pin_inc_sig;
            ADVERTENCIA          <= adv_sig;
            BLOQUEO              <= bloq_sig;
            FONDOS_INSUFICIENTES <= fondos_sig;
            LIMITE_EXCEDIDO      <= limite_sig;
            if (estado == ESPERA_MONTO && MONTO_STB) begin
                monto_reg <= MONTO;
                tipo_reg  <= TIPO_TRANS;
            end
        end
    end

endmodule

// File: tb/tb_cajero_parametrizado.sv
// Scoreboard bench for cajero_parametrizado: two instances (defaults, and
// a 6-digit / 32-bit-balance variant). Stimulus pushes expected result
// events from a transaction-level model; a monitor pops on every pulse.
module tb_cajero_parametrizado;

    localparam int          MAX = 3;
    localparam logic [31:0] LIM = 32'd50000;

    typedef struct packed {
        logic [4:0]  pulsos;  // {act, entregar, pin_inc, fondos, limite}
        logic        adv;
        logic        bloq;
        logic [63:0] bal;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, card, dstb, mstb, tipo;
    logic [1:0][3:0]  dig;
    logic [1:0][31:0] monto;
    logic [63:0]      bal_a;
    logic [31:0]      bal_b;
    logic [1:0]       bact, entr, pinc, adv, bloq, fondos, lim;

    logic [15:0] pin_a = 16'h1234;
    logic [23:0] pin_b = 24'h654321;

    cajero_parametrizado dut_a (
        .CLK(clk), .RESET(rst_n[0]), .TARJETA_RECIBIDA(card[0]), .PIN(pin_a),
        .DIGITO(dig[0]), .DIGITO_STB(dstb[0]), .TIPO_TRANS(tipo[0]),
        .MONTO(monto[0]), .MONTO_STB(mstb[0]), .BALANCE(bal_a),
        .BALANCE_ACTUALIZADO(bact[0]), .ENTREGAR_DINERO(entr[0]),
        .PIN_INCORRECTO(pinc[0]), .ADVERTENCIA(adv[0]), .BLOQUEO(bloq[0]),
        .FONDOS_INSUFICIENTES(fondos[0]), .LIMITE_EXCEDIDO(lim[0])
    );

    cajero_parametrizado #(
        .N_DIGITOS(6), .BAL_W(32), .BALANCE_INI(32'hFFFF_FF00)
    ) dut_b (
        .CLK(clk), .RESET(rst_n[1]), .TARJETA_RECIBIDA(card[1]), .PIN(pin_b),
        .DIGITO(dig[1]), .DIGITO_STB(dstb[1]), .TIPO_TRANS(tipo[1]),
        .MONTO(monto[1]), .MONTO_STB(mstb[1]), .BALANCE(bal_b),
        .BALANCE_ACTUALIZADO(bact[1]), .ENTREGAR_DINERO(entr[1]),
        .PIN_INCORRECTO(pinc[1]), .ADVERTENCIA(adv[1]), .BLOQUEO(bloq[1]),
        .FONDOS_INSUFICIENTES(fondos[1]), .LIMITE_EXCEDIDO(lim[1])
    );

    int compared = 0;
    int mismatched = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Transaction-level reference model
    logic [63:0] m_bal [2];
    int          m_fallos [2];
    logic        m_adv [2];
    logic        m_bloq [2];

    function automatic logic [63:0] ini(int d);
        return (d == 0) ? 64'd1000 : 64'h0000_0000_FFFF_FF00;
    endfunction

    function automatic logic [63:0] tope(int d);
        return (d == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [31:0] pin_de(int d);
        return (d == 0) ? 32'h1234 : 32'h654321;
    endfunction

    function automatic int ndig(int d);
        return (d == 0) ? 4 : 6;
    endfunction

    task automatic push(int d, logic [4:0] p);
        exp_t e;
        e.pulsos = p;
        e.adv    = m_adv[d];
        e.bloq   = m_bloq[d];
        e.bal    = m_bal[d];
        if (d == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic expect_eq(string name, logic [63:0] got, logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: any pulse on a DUT must match the next queued expectation.
    task automatic check(int d);
        exp_t got, e;
        got = {bact[d], entr[d], pinc[d], fondos[d], lim[d], adv[d], bloq[d],
               (d == 0) ? bal_a : {32'b0, bal_b}};
        compared++;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            mismatched++;
            $display("FAIL unexpected_event dut%0d: got %h with nothing expected", d, got);
        end else begin
            e = (d == 0) ? qa.pop_front() : qb.pop_front();
            if (got !== e) begin
                mismatched++;
                $display("FAIL event dut%0d: got %h expected %h", d, got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (rst_n[d] && (bact[d] | entr[d] | pinc[d] | fondos[d] | lim[d]))
                check(d);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int d);
        expect_eq($sformatf("drained_before_reset%0d", d),
                  64'((d == 0) ? qa.size() : qb.size()), 64'd0);
        rst_n[d] = 1'b0;
        tick();
        rst_n[d] = 1'b1;
        m_bal[d] = ini(d); m_fallos[d] = 0; m_adv[d] = 1'b0; m_bloq[d] = 1'b0;
        expect_eq($sformatf("reset_flags%0d", d),
                  64'({bact[d], entr[d], pinc[d], adv[d], bloq[d], fondos[d], lim[d]}), 64'd0);
        expect_eq($sformatf("reset_balance%0d", d),
                  (d == 0) ? bal_a : {32'b0, bal_b}, ini(d));
    endtask

    task automatic start_session(int d);
        card[d] = 1'b1;
        tick();
    endtask

    task automatic enter_digits(int d, logic [31:0] val, int n);
        for (int i = n - 1; i >= 0; i--) begin
            dig[d]  = val[4*i +: 4];
            dstb[d] = 1'b1;
            tick();
            dstb[d] = 1'b0;
            if (i != 0) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic pin_attempt(int d, logic [31:0] val);
        if (val == pin_de(d)) begin
            m_fallos[d] = 0;
            m_adv[d] = 1'b0;
        end else begin
            m_fallos[d]++;
            if (m_fallos[d] == MAX) begin
                m_bloq[d] = 1'b1;
                m_adv[d]  = 1'b0;
            end else if (m_fallos[d] == MAX - 1) begin
                m_adv[d] = 1'b1;
            end
            push(d, 5'b00100);
        end
        enter_digits(d, val, ndig(d));
        tick();
        expect_eq($sformatf("adv_level%0d", d), 64'(adv[d]), 64'(m_adv[d]));
        expect_eq($sformatf("bloq_level%0d", d), 64'(bloq[d]), 64'(m_bloq[d]));
    endtask

    task automatic transaction(int d, logic tt, logic [31:0] m);
        logic [64:0] s;
        if (tt) begin
            if (m > LIM) push(d, 5'b00001);
            else if ({32'b0, m} > m_bal[d]) push(d, 5'b00010);
            else begin
                m_bal[d] = m_bal[d] - {32'b0, m};
                push(d, 5'b11000);
            end
        end else begin
            s = {1'b0, m_bal[d]} + {33'b0, m};
            m_bal[d] = (s > {1'b0, tope(d)}) ? tope(d) : s[63:0];
            push(d, 5'b10000);
        end
        tipo[d]  = tt;
        monto[d] = m;
        mstb[d]  = 1'b1;
        tick();
        mstb[d]  = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [31:0] wrong_pin(int d);
        logic [31:0] v;
        v = pin_de(d);
        return v ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, ndig(d) - 1)));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] m;
        rst_n = '0; card = '0; dstb = '0; mstb = '0; tipo = '0; dig = '0; monto = '0;
        tick();
        rst_n = '1;
        do_reset(0);
        do_reset(1);

        // T1: correct PIN, withdraw 300
        start_session(0);
        pin_attempt(0, 32'h1234);
        transaction(0, 1'b1, 32'd300);
        expect_eq("t1_balance", bal_a, 64'd700);

        // T2: two wrong then correct; zero deposit; card drop mid-session
        start_session(0);
        pin_attempt(0, 32'h1235);
        pin_attempt(0, 32'h1235);
        expect_eq("t2_warning", 64'(adv[0]), 64'd1);
        card[0] = 1'b0;
        pin_attempt(0, 32'h1234);
        transaction(0, 1'b0, 32'd0);

        // T3: lockout, ignored strobes, reset
        start_session(0);
        repeat (3) pin_attempt(0, 32'h9999);
        enter_digits(0, 32'h1234, 4);
        tipo[0] = 1'b0; monto[0] = 32'd5; mstb[0] = 1'b1; tick(); mstb[0] = 1'b0;
        repeat (4) tick();
        expect_eq("t3_locked", 64'(bloq[0]), 64'd1);
        do_reset(0);

        // T4: limit, insufficient funds, exact-balance withdrawal
        start_session(0); pin_attempt(0, 32'h1234); transaction(0, 1'b1, 32'd60000);
        start_session(0); pin_attempt(0, 32'h1234); transaction(0, 1'b1, 32'd1001);
        start_session(0); pin_attempt(0, 32'h1234); transaction(0, 1'b1, 32'd1000);
        expect_eq("t4_balance_zero", bal_a, 64'd0);

        // Randomised sessions on the default instance
        for (int k = 0; k < 40; k++) begin
            start_session(0);
            repeat ($urandom_range(0, 3)) begin
                pin_attempt(0, wrong_pin(0));
                if (m_bloq[0]) begin
                    tick();
                    do_reset(0);
                    start_session(0);
                end
            end
            pin_attempt(0, 32'h1234);
            case ($urandom_range(0, 6))
                0: m = 32'd0;
                1: m = m_bal[0][31:0];
                2: m = m_bal[0][31:0] + 32'd1;
                3: m = LIM;
                4: m = LIM + 32'd1;
                5: m = 32'($urandom_range(0, 2000));
                default: m = $urandom;
            endcase
            transaction(0, 1'($urandom_range(0, 1)), m);
            if ($urandom_range(0, 3) == 0) card[0] = 1'b0;
        end

        // T6: reset mid-PIN on the 6-digit instance, then accepted PIN
        start_session(1);
        enter_digits(1, 32'h654, 3);
        do_reset(1);
        start_session(1);
        pin_attempt(1, 32'h654321);
        // T5: saturating deposit
        transaction(1, 1'b0, 32'h200);
        expect_eq("t5_saturated", {32'b0, bal_b}, 64'hFFFF_FFFF);
        start_session(1); pin_attempt(1, 32'h654321); transaction(1, 1'b1, 32'hFFFF_FFFF);
        start_session(1); pin_attempt(1, 32'h654321); transaction(1, 1'b1, LIM);

        repeat (5) tick();
        expect_eq("queue_a_empty", 64'(qa.size()), 64'd0);
        expect_eq("queue_b_empty", 64'(qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
